// File: rtl/data_mem_if.sv
// Processor data-memory port: level requests in, registered read
// response and status out.
interface data_mem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        rvalid;
    logic        busy;
    logic        addr_err;
    logic        proto_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output MemRead, MemWrite, dAddress, dWriteData,
        input  dReadData, rvalid, busy, addr_err,
        input  proto_err, rd_count, wr_count
    );

    modport slave (
        input  MemRead, MemWrite, dAddress, dWriteData,
        output dReadData, rvalid, busy, addr_err,
        output proto_err, rd_count, wr_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with configurable read latency,
// range/alignment checking and access counters.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  LAT_M1 = 3'(READ_LATENCY - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ok_q, ok_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               aerr_q, aerr_d;
    logic               perr_q, perr_d;
    logic [15:0]        rdc_q, rdc_d;
    logic [15:0]        wrc_q, wrc_d;

    logic [31:0]        offset;
    logic               req_ok;
    logic [IDX_W-1:0]   req_idx;
    logic               we;
    logic               cmp_en;
    logic               cmp_ok;
    logic [IDX_W-1:0]   cmp_idx;

    // Offset wraps for addresses below the base, so the lower bound
    // must be checked on the raw address.
    assign offset  = bus.dAddress - BASE_ADDR;
    assign req_ok  = (bus.dAddress[1:0] == 2'b00)
                  && (bus.dAddress >= BASE_ADDR)
                  && (offset < SPAN);
    assign req_idx = offset[IDX_W+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ok_d     = ok_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        aerr_d   = 1'b0;
        perr_d   = perr_q;
        rdc_d    = rdc_q;
        wrc_d    = wrc_q;
        we       = 1'b0;
        cmp_en   = 1'b0;
        cmp_ok   = 1'b0;
        cmp_idx  = req_idx;

        unique case (state_q)
            IDLE: begin
                if (bus.MemWrite) begin
                    we = req_ok;
                    if (req_ok) wrc_d = wrc_q + 16'd1;
                    else        aerr_d = 1'b1;
                    if (bus.MemRead) perr_d = 1'b1;
                end else if (bus.MemRead) begin
                    if (READ_LATENCY == 1) begin
                        cmp_en  = 1'b1;
                        cmp_ok  = req_ok;
                        cmp_idx = req_idx;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_M1;
                        idx_d   = req_idx;
                        ok_d    = req_ok;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd1) begin
                    cmp_en  = 1'b1;
                    cmp_ok  = ok_q;
                    cmp_idx = idx_q;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmp_en) begin
            rvalid_d = 1'b1;
            if (cmp_ok) begin
                rdata_d = mem[cmp_idx];
                rdc_d   = rdc_q + 16'd1;
            end else begin
                rdata_d = 32'h0;
                aerr_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            ok_q     <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
            perr_q   <= 1'b0;
            rdc_q    <= 16'd0;
            wrc_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ok_q     <= ok_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
            perr_q   <= perr_d;
            rdc_q    <= rdc_d;
            wrc_q    <= wrc_d;
        end
    end

    // Array is deliberately not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[req_idx] <= bus.dWriteData;
        end
    end

    assign bus.dReadData = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.busy      = (state_q == RD_WAIT);
    assign bus.addr_err  = aerr_q;
    assign bus.proto_err = perr_q;
    assign bus.rd_count  = rdc_q;
    assign bus.wr_count  = wrc_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus queues expected read responses, a
// negedge monitor pops them whenever a DUT raises rvalid.
module tb_data_mem_responder;
    logic clk;
    logic rst1, rst3, rst4;
    int   checks;
    int   failures;

    typedef struct packed {
        logic [31:0] data;
        logic        aerr;
    } exp_t;

    exp_t sbq [3][$];

    data_mem_if b1 ();
    data_mem_if b3 ();
    data_mem_if b4 ();

    data_mem_responder u1 (.clk(clk), .rst(rst1), .bus(b1));
    data_mem_responder #(.READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst3), .bus(b3));
    data_mem_responder #(.READ_LATENCY(4)) u4 (
        .clk(clk), .rst(rst4), .bus(b4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic rv, input logic ae,
                       input logic [31:0] rd);
        exp_t e;
        if (rv === 1'b1) begin
            if (sbq[id].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid dut%0d got data=%h required no response",
                         id, rd);
            end else begin
                e = sbq[id].pop_front();
                chk($sformatf("rdata_dut%0d", id), rd, e.data);
                chk($sformatf("rd_addr_err_dut%0d", id), 32'(ae), 32'(e.aerr));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, b1.rvalid, b1.addr_err, b1.dReadData);
        mon(1, b3.rvalid, b3.addr_err, b3.dReadData);
        mon(2, b4.rvalid, b4.addr_err, b4.dReadData);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        case (id)
            0: begin
                b1.MemRead = r; b1.MemWrite = w;
                b1.dAddress = a; b1.dWriteData = d;
            end
            1: begin
                b3.MemRead = r; b3.MemWrite = w;
                b3.dAddress = a; b3.dWriteData = d;
            end
            default: begin
                b4.MemRead = r; b4.MemWrite = w;
                b4.dAddress = a; b4.dWriteData = d;
            end
        endcase
    endtask

    task automatic access(input int id, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        drive(id, r, w, a, d);
        cyc();
        drive(id, 1'b0, 1'b0, a, d);
    endtask

    task automatic push(input int id, input logic [31:0] d,
                        input logic ae);
        exp_t e;
        e.data = d;
        e.aerr = ae;
        sbq[id].push_back(e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

        chk("rst_rdata", b1.dReadData, 32'h0);
        chk("rst_rvalid", 32'(b1.rvalid), 32'h0);
        chk("rst_busy", 32'(b1.busy), 32'h0);
        chk("rst_addr_err", 32'(b1.addr_err), 32'h0);
        chk("rst_proto_err", 32'(b1.proto_err), 32'h0);
        chk("rst_rd_count", 32'(b1.rd_count), 32'h0);
        chk("rst_wr_count", 32'(b1.wr_count), 32'h0);

        access(0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
        chk("wr_count_1", 32'(b1.wr_count), 32'd1);
        chk("wr_no_aerr", 32'(b1.addr_err), 32'h0);
        push(0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
        chk("rvalid_lat1", 32'(b1.rvalid), 32'h1);
        chk("rd_count_1", 32'(b1.rd_count), 32'd1);

        push(0, 32'h0, 1'b1);
        access(0, 1'b1, 1'b0, 32'h1001_0402, 32'h0);
        push(0, 32'h0, 1'b1);
        access(0, 1'b1, 1'b0, 32'h1001_0400, 32'h0);
        chk("rd_count_bad_rd", 32'(b1.rd_count), 32'd1);

        access(0, 1'b0, 1'b1, 32'h1001_03FC, 32'hA5A5_A5A5);
        chk("wr_count_last", 32'(b1.wr_count), 32'd2);
        access(0, 1'b0, 1'b1, 32'h1000_FFFC, 32'hBAD0_BAD0);
        chk("wr_bad_aerr", 32'(b1.addr_err), 32'h1);
        chk("wr_bad_rvalid", 32'(b1.rvalid), 32'h0);
        chk("wr_bad_count", 32'(b1.wr_count), 32'd2);
        cyc();
        chk("aerr_pulse_end", 32'(b1.addr_err), 32'h0);
        push(0, 32'hA5A5_A5A5, 1'b0);
        access(0, 1'b1, 1'b0, 32'h1001_03FC, 32'h0);
        chk("rd_count_2", 32'(b1.rd_count), 32'd2);

        drive(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
        push(0, 32'hDEAD_BEEF, 1'b0);
        push(0, 32'hDEAD_BEEF, 1'b0);
        cyc();
        cyc();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("held_rd_count", 32'(b1.rd_count), 32'd4);

        access(0, 1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678);
        chk("proto_set", 32'(b1.proto_err), 32'h1);
        chk("proto_wr_count", 32'(b1.wr_count), 32'd3);
        chk("proto_no_rvalid", 32'(b1.rvalid), 32'h0);
        repeat (3) cyc();
        chk("proto_sticky", 32'(b1.proto_err), 32'h1);
        push(0, 32'h1234_5678, 1'b0);
        access(0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        chk("proto_rd_count", 32'(b1.rd_count), 32'd5);

        rst1 = 1'b1;
        access(0, 1'b0, 1'b1, 32'h1001_03FC, 32'h0);
        rst1 = 1'b0;
        chk("rst2_proto", 32'(b1.proto_err), 32'h0);
        chk("rst2_wr_count", 32'(b1.wr_count), 32'h0);
        chk("rst2_rd_count", 32'(b1.rd_count), 32'h0);
        chk("rst2_rdata", b1.dReadData, 32'h0);
        push(0, 32'hA5A5_A5A5, 1'b0);
        access(0, 1'b1, 1'b0, 32'h1001_03FC, 32'h0);
        push(0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);

        rst1 = 1'b1;
        cyc();
        rst1 = 1'b0;
        drive(0, 1'b0, 1'b1, 32'h1001_0010, 32'h0000_0010);
        repeat (65535) cyc();
        chk("wr_count_ffff", 32'(b1.wr_count), 32'h0000_FFFF);
        cyc();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wr_count_wrap", 32'(b1.wr_count), 32'h0);

        access(1, 1'b0, 1'b1, 32'h1001_0004, 32'h1111_2222);
        push(1, 32'h1111_2222, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        cyc();
        chk("l3_busy_1", 32'(b3.busy), 32'h1);
        chk("l3_rvalid_1", 32'(b3.rvalid), 32'h0);
        drive(1, 1'b0, 1'b1, 32'h1001_0004, 32'hFFFF_FFFF);
        cyc();
        chk("l3_busy_2", 32'(b3.busy), 32'h1);
        chk("l3_rvalid_2", 32'(b3.rvalid), 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("l3_rvalid_3", 32'(b3.rvalid), 32'h1);
        chk("l3_busy_3", 32'(b3.busy), 32'h0);
        chk("l3_wr_count", 32'(b3.wr_count), 32'd1);
        chk("l3_rd_count", 32'(b3.rd_count), 32'd1);
        push(1, 32'h1111_2222, 1'b0);
        access(1, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        repeat (3) cyc();
        chk("l3_rd_count_2", 32'(b3.rd_count), 32'd2);

        access(2, 1'b0, 1'b1, 32'h1001_0020, 32'hCAFE_F00D);
        access(2, 1'b1, 1'b0, 32'h1001_0020, 32'h0);
        chk("l4_busy_1", 32'(b4.busy), 32'h1);
        cyc();
        chk("l4_busy_2", 32'(b4.busy), 32'h1);
        rst4 = 1'b1;
        cyc();
        rst4 = 1'b0;
        chk("l4_abort_busy", 32'(b4.busy), 32'h0);
        chk("l4_abort_rvalid", 32'(b4.rvalid), 32'h0);
        chk("l4_abort_rdata", b4.dReadData, 32'h0);
        chk("l4_abort_rd_count", 32'(b4.rd_count), 32'h0);
        chk("l4_abort_wr_count", 32'(b4.wr_count), 32'h0);
        repeat (5) cyc();
        push(2, 32'hCAFE_F00D, 1'b0);
        access(2, 1'b1, 1'b0, 32'h1001_0020, 32'h0);
        repeat (4) cyc();
        chk("l4_rd_count", 32'(b4.rd_count), 32'd1);

        access(2, 1'b0, 1'b1, 32'h1001_0024, 32'h0000_5555);
        rst4 = 1'b1;
        access(2, 1'b0, 1'b1, 32'h1001_0024, 32'h0000_6666);
        rst4 = 1'b0;
        push(2, 32'h0000_5555, 1'b0);
        access(2, 1'b1, 1'b0, 32'h1001_0024, 32'h0);
        repeat (5) cyc();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pending_dut%0d", i), 32'(sbq[i].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 4..4096.
REQ-003 Parameter READ_LATENCY, default 1, rising edges from read sample to data valid; legal 1..4.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 MemRead  input  1  processor read request, level, sampled each rising edge.
REQ-007 MemWrite  input  1  processor write request, level, sampled each rising edge.
REQ-008 dAddress  input  32  byte address of access.
REQ-009 dWriteData  input  32  write data.
REQ-010 dReadData  output  32  registered read data, held until next read completion.
REQ-011 rvalid  output  1  one-cycle pulse: dReadData updated this cycle.
REQ-012 busy  output  1  high while in RD_WAIT.
REQ-013 addr_err  output  1  one-cycle pulse: completed access was out of range or misaligned.
REQ-014 proto_err  output  1  sticky: MemRead and MemWrite sampled high together.
REQ-015 rd_count  output  16  successful reads, wraps modulo 2^16.
REQ-016 wr_count  output  16  successful writes, wraps modulo 2^16.

Function
REQ-017 Address valid iff dAddress[1:0]==0 and BASE_ADDR <= dAddress < BASE_ADDR+4*DEPTH_WORDS; word index = (dAddress-BASE_ADDR)>>2, 32-bit unsigned arithmetic.
REQ-018 FSM states IDLE and RD_WAIT only; requests accepted only in IDLE.
REQ-019 IDLE, MemWrite=1: valid address -> mem[index] <= dWriteData at that edge, wr_count+1; invalid -> no array change, addr_err pulses next cycle.
REQ-020 IDLE, MemRead=1, MemWrite=0: address and validity captured at sampling edge.
REQ-021 READ_LATENCY=1: dReadData and rvalid updated at the sampling edge itself; FSM stays IDLE.
REQ-022 READ_LATENCY=N>1: go to RD_WAIT, load counter N-1, decrement each edge; at edge where counter is 1, update dReadData, pulse rvalid, return IDLE.
REQ-023 Read completion: valid -> dReadData=mem[captured index], rd_count+1; invalid -> dReadData=32'h0, addr_err pulses with rvalid, rd_count unchanged.
REQ-024 Read data reflects array contents at completion edge; write at edge k is visible to read sampled at edge k+1.
REQ-025 MemRead and MemWrite both high in IDLE: write performed per REQ-019, read discarded, proto_err set until reset.
REQ-026 MemRead/MemWrite in RD_WAIT: ignored, no array/counter change, no error flag.
REQ-027 Level request held high for several cycles: each IDLE sampling edge is a new access (processor holds request exactly one cycle).
REQ-028 rvalid and addr_err never high more than one consecutive cycle per access.

Reset
REQ-029 rst=1 at edge: state IDLE, counter 0, dReadData=0, rvalid=0, busy=0, addr_err=0, proto_err=0, rd_count=0, wr_count=0.
REQ-030 Array contents are not reset; they keep prior values across rst.
REQ-031 rst during RD_WAIT aborts the read: no rvalid, no rd_count change; rst over MemWrite at same edge suppresses the write.

Verification
REQ-032 Default params: write 32'hDEADBEEF to 32'h10010008, then read 32'h10010008 next cycle -> rvalid one cycle later, dReadData=32'hDEADBEEF, wr_count=1, rd_count=1.
REQ-033 READ_LATENCY=3: read at edge 0 -> busy high 2 cycles, rvalid and data at edge 2; MemWrite pulsed during busy -> array unchanged.
REQ-034 Read 32'h10010402 (misaligned) and 32'h10010400 (out of range, depth 256) -> dReadData=0, addr_err with rvalid, rd_count unchanged; write to 32'h1000FFFC -> no array change, addr_err next cycle.
REQ-035 MemRead=MemWrite=1 at 32'h10010000 with data 32'h12345678 -> mem[0]=32'h12345678, no rvalid, proto_err=1 until rst.
REQ-036 Preload wr_count to 16'hFFFF via 65535 writes, one more write -> wr_count=16'h0000.
REQ-037 READ_LATENCY=4, rst asserted second cycle of RD_WAIT -> no rvalid ever, outputs at reset values, prior written data still readable afterward.
